// File: rtl/sdram_bridge_pkg.sv
// Shared types and helpers for the 32-bit word to 8-bit SDRAM controller bridge.
package sdram_bridge_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       none_left;
    logic [1:0] lane;
  } lane_sel_t;

  // Lowest enabled lane strictly above `lane`; none_left is set when no such lane exists.
  function automatic lane_sel_t next_lane(input logic [BYTES_PER_WORD-1:0] be,
                                          input logic [1:0] lane);
    lane_sel_t sel;
    sel.none_left = 1'b1;
    sel.lane      = lane;
    for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
      if (be[i] && (i > int'(lane))) begin
        sel.none_left = 1'b0;
        sel.lane      = 2'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sdram_word_bridge.sv
// Serializes 32-bit host word requests into byte accesses on the 8-bit SDRAM
// controller handshake and reassembles read bytes into a single word response.
module sdram_word_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int HADDR_WIDTH = 25,
  parameter int WADDR_WIDTH = HADDR_WIDTH - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [WADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_be,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]             wr_data,
  output logic                   wr_enable,
  output logic                   rd_enable,
  input  logic [7:0]             rd_data,
  input  logic                   ack,
  input  logic                   rd_ready
);

  state_e                   state_q, state_d;
  logic [WADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               be_q, be_d;
  logic [1:0]               lane_q, lane_d;
  logic [31:0]              rword_q, rword_d;

  logic                     req_ready_q, req_ready_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [31:0]              resp_rdata_q, resp_rdata_d;
  logic [HADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [HADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]               wr_data_q, wr_data_d;
  logic                     wr_enable_q, wr_enable_d;
  logic                     rd_enable_q, rd_enable_d;

  lane_sel_t                first_sel, next_sel;

  // First lane of a new write counts from lane 0; later lanes from the current one.
  assign first_sel = next_lane(req_be, 2'd0);
  assign next_sel  = next_lane(be_q, lane_q);

  // Next-state logic; every output is derived from the next state so it is registered.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    lane_d       = lane_q;
    rword_d      = rword_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (!req_write) begin
            lane_d  = 2'd0;
            state_d = S_RD_REQ;
          end else if (!req_be[0] && first_sel.none_left) begin
            // Nothing enabled: complete without touching the controller.
            state_d = S_DONE;
          end else begin
            lane_d  = req_be[0] ? 2'd0 : first_sel.lane;
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (ack) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_ready) begin
          for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (lane_q == 2'(b)) rword_d[8*b +: 8] = rd_data;
          end
          if (lane_q == 2'd3) begin
            resp_rdata_d = rword_d;
            state_d      = S_DONE;
          end else begin
            lane_d  = lane_q + 2'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (ack) begin
          if (next_sel.none_left) state_d = S_DONE;
          else                    lane_d  = next_sel.lane;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    rd_enable_d  = (state_d == S_RD_REQ);
    wr_enable_d  = (state_d == S_WR_REQ);

    // Addresses and write byte only move when a new access is being presented.
    rd_addr_d = rd_enable_d ? {addr_d, lane_d} : rd_addr_q;
    wr_addr_d = wr_enable_d ? {addr_d, lane_d} : wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_enable_d) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (lane_d == 2'(b)) wr_data_d = wdata_d[8*b +: 8];
      end
    end
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      lane_q       <= '0;
      rword_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_enable_q  <= 1'b0;
      rd_enable_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      lane_q       <= lane_d;
      rword_q      <= rword_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_data_q    <= wr_data_d;
      wr_enable_q  <= wr_enable_d;
      rd_enable_q  <= rd_enable_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign wr_addr    = wr_addr_q;
  assign rd_addr    = rd_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_enable  = wr_enable_q;
  assign rd_enable  = rd_enable_q;

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Scoreboard bench for sdram_word_bridge with a byte-wide controller model.
module tb_sdram_word_bridge;

  localparam int RD_LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [22:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [24:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        wr_enable, rd_enable;
  logic [7:0]  rd_data = '0;
  logic        ack = 1'b0;
  logic        rd_ready = 1'b0;

  sdram_word_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
    .wr_enable(wr_enable), .rd_enable(rd_enable),
    .rd_data(rd_data), .ack(ack), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    bit          has_bytes;
    logic [31:0] rdata;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic        is_wr;
    logic [24:0] addr;
    logic [7:0]  data;
  } acc_t;

  exp_t        exp_q[$];
  acc_t        acc_q[$];
  logic [7:0]  ref_mem [logic [24:0]];
  logic [7:0]  ctl_mem [logic [24:0]];
  logic [31:0] last_rd = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_delay = 1;
  int last_ack_cyc = 0;
  int last_rdy_cyc = 0;
  int rd_ack_cnt = 0;
  int wr_acc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Background contents for bytes never written.
  function automatic logic [7:0] pat(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [24:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  function automatic logic [7:0] ctl_rd(input logic [24:0] a);
    if (ctl_mem.exists(a)) return ctl_mem[a];
    return pat(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request, wait for acceptance and record what the word-level model expects.
  task automatic issue(input bit wr, input logic [22:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t        e;
    acc_t        ac;
    logic [31:0] word;
    int          guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    guard = 0;
    while (!req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.is_read   = !wr;
    e.has_bytes = !wr || (be != 4'd0);
    e.acc_cyc   = cyc;
    if (!wr) begin
      word = '0;
      for (int b = 0; b < 4; b++) begin
        ac.is_wr = 1'b0; ac.addr = {a, 2'(b)}; ac.data = 8'h00;
        acc_q.push_back(ac);
        word[8*b +: 8] = ref_rd({a, 2'(b)});
      end
      last_rd = word;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          ac.is_wr = 1'b1; ac.addr = {a, 2'(b)}; ac.data = d[8*b +: 8];
          acc_q.push_back(ac);
          ref_mem[{a, 2'(b)}] = d[8*b +: 8];
        end
      end
    end
    e.rdata = last_rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 23'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || !req_ready) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Controller model: ack one cycle into each access (or after ack_delay), rd_ready RD_LAT after a read ack.
  logic        prev_en = 1'b0;
  logic        sv_wr, cur_wr;
  logic [24:0] sv_addr, cur_addr, rd_pend_addr;
  logic [7:0]  sv_data, cur_data;
  int          cnt = 0;
  int          rd_cd = 0;
  acc_t        got;

  always @(negedge clk) begin
    if (rd_ready) rd_ready = 1'b0;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin
        rd_ready     = 1'b1;
        rd_data      = ctl_rd(rd_pend_addr);
        last_rdy_cyc = cyc;
      end
    end
    if (!rd_ready) rd_data = 8'($urandom);

    if (!rst_n) begin
      ack = 1'b0; cnt = 0; prev_en = 1'b0;
    end else if (ack) begin
      ack = 1'b0; cnt = 0; prev_en = 1'b0;
    end else if (wr_enable || rd_enable) begin
      tests++;
      if (wr_enable && rd_enable) begin
        fails++;
        $display("FAIL enable_overlap: got wr_enable=1 rd_enable=1 required at most one");
      end
      cur_wr   = wr_enable;
      cur_addr = wr_enable ? wr_addr : rd_addr;
      cur_data = wr_enable ? wr_data : 8'h00;
      if (prev_en) begin
        tests++;
        if ({cur_wr, cur_addr, cur_data} !== {sv_wr, sv_addr, sv_data}) begin
          fails++;
          $display("FAIL held_request: got wr=%0d addr=0x%0h data=0x%0h required wr=%0d addr=0x%0h data=0x%0h",
                   cur_wr, cur_addr, cur_data, sv_wr, sv_addr, sv_data);
        end
      end
      sv_wr = cur_wr; sv_addr = cur_addr; sv_data = cur_data;
      prev_en = 1'b1;
      cnt++;
      if (cnt >= ack_delay) begin
        ack = 1'b1;
        last_ack_cyc = cyc;
        tests++;
        if (acc_q.size() == 0) begin
          fails++;
          $display("FAIL access: got wr=%0d addr=0x%0h with no access expected", cur_wr, cur_addr);
        end else begin
          got = acc_q.pop_front();
          if (got.is_wr !== cur_wr || got.addr !== cur_addr || (cur_wr && got.data !== cur_data)) begin
            fails++;
            $display("FAIL access: got wr=%0d addr=0x%0h data=0x%0h required wr=%0d addr=0x%0h data=0x%0h",
                     cur_wr, cur_addr, cur_data, got.is_wr, got.addr, got.data);
          end
        end
        if (cur_wr) begin
          ctl_mem[cur_addr] = cur_data;
          wr_acc_cnt++;
        end else begin
          rd_pend_addr = cur_addr;
          rd_cd        = RD_LAT;
          rd_ack_cnt++;
        end
      end
    end else begin
      prev_en = 1'b0; cnt = 0;
    end
  end

  // Response monitor: every resp_valid pulse must match the oldest outstanding request.
  exp_t mon_e;
  int   mon_want;
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got resp_valid=1 rdata=0x%0h required no response", resp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (resp_rdata !== mon_e.rdata) begin
          fails++;
          $display("FAIL resp_rdata: got 0x%0h required 0x%0h (read=%0d)", resp_rdata, mon_e.rdata, mon_e.is_read);
        end
        // Response lands in the cycle after the final rd_ready / final ack / acceptance.
        mon_want = mon_e.is_read ? last_rdy_cyc + 1 :
                   (mon_e.has_bytes ? last_ack_cyc + 1 : mon_e.acc_cyc + 1);
        tests++;
        if (cyc != mon_want) begin
          fails++;
          $display("FAIL resp_timing: got cycle %0d required cycle %0d", cyc, mon_want);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] pre_bytes [4];
  int         base, guard, wr_before, t0;

  initial begin
    pre_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_enables", {30'd0, wr_enable, rd_enable}, 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(req_ready), 32'd1);

    // Directed read of word 0x12345: byte addresses 0x48D14..0x48D17.
    for (int b = 0; b < 4; b++) begin
      ref_mem[{23'h12345, 2'(b)}] = pre_bytes[b];
      ctl_mem[{23'h12345, 2'(b)}] = pre_bytes[b];
    end
    issue(1'b0, 23'h12345, 32'h0, 4'h0);
    wait_idle();
    chk("read_word", resp_rdata, 32'h44332211);

    // Sparse write: lanes 1 and 3 only.
    wr_before = wr_acc_cnt;
    issue(1'b1, 23'h100, 32'hAABBCCDD, 4'b1010);
    wait_idle();
    chk("sparse_write_count", 32'(wr_acc_cnt - wr_before), 32'd2);
    chk("sparse_lane1", 32'(ctl_rd({23'h100, 2'd1})), 32'hCC);
    chk("sparse_lane3", 32'(ctl_rd({23'h100, 2'd3})), 32'hAA);
    chk("resp_rdata_hold", resp_rdata, 32'h44332211);

    // Empty byte enable: no controller traffic.
    wr_before = wr_acc_cnt;
    issue(1'b1, 23'h101, 32'h01020304, 4'b0000);
    wait_idle();
    chk("empty_be_writes", 32'(wr_acc_cnt - wr_before), 32'd0);

    // Refresh-delayed acks: requests must stay stable through the stall.
    ack_delay = 40;
    t0 = cyc;
    issue(1'b1, 23'h200, 32'h5566_7788, 4'b1111);
    wait_idle();
    ack_delay = 1;
    tests++;
    if (cyc - t0 < 160) begin
      fails++;
      $display("FAIL refresh_stall: got %0d cycles required at least 160", cyc - t0);
    end

    // Reset while waiting for the lane-2 read byte.
    base = rd_ack_cnt;
    issue(1'b0, 23'h3, 32'h0, 4'h0);
    guard = 0;
    while (rd_ack_cnt < base + 3 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("lane2_read_ack", 32'(rd_ack_cnt - base), 32'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_enables", {30'd0, wr_enable, rd_enable}, 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_resp", 32'(resp_valid), 32'd0);
    exp_q.delete(); acc_q.delete(); last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("ready_after_mid_rst", 32'(req_ready), 32'd1);
    chk("rdata_after_mid_rst", resp_rdata, 32'd0);

    // Reset while a write is stalled with wr_enable high: the enable must drop asynchronously.
    ack_delay = 40;
    issue(1'b1, 23'h400000, 32'h1234_5678, 4'b1111);
    repeat (10) @(negedge clk);
    chk("stalled_wr_enable", 32'(wr_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_enable_async", 32'(wr_enable), 32'd0);
    exp_q.delete(); acc_q.delete(); last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 1;
    repeat (3) @(negedge clk);

    // Back-to-back write then read of word 0.
    issue(1'b1, 23'h0, 32'h0000_00FF, 4'b0001);
    issue(1'b0, 23'h0, 32'h0, 4'h0);
    wait_idle();
    chk("b2b_low_byte", 32'(resp_rdata[7:0]), 32'hFF);

    // Randomized traffic over a small address window so reads revisit written bytes.
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom_range(0, 1)), 23'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    end
    wait_idle();
    chk("final_acc_queue", 32'(acc_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
